// File: rtl/inst_encoder_if.sv
// Request/response bundle for the RV32I instruction encoder.
// The master drives requests and output-side ready; the slave is the encoder.
interface inst_encoder_if #(
    parameter int cCntW = 16
);
    logic             iValid;
    logic             oReady;
    logic [6:0]       iOpcode;
    logic [4:0]       iRdAddr;
    logic [4:0]       iRs1Addr;
    logic [4:0]       iRs2Addr;
    logic [2:0]       iFunct3;
    logic [6:0]       iFunct7;
    logic [31:0]      iImm;
    logic             oValid;
    logic             iReady;
    logic [31:0]      oInst;
    logic             oIllegal;
    logic [cCntW-1:0] oAccCnt;
    logic [cCntW-1:0] oIllCnt;

    modport master (
        output iValid, iOpcode, iRdAddr, iRs1Addr, iRs2Addr, iFunct3, iFunct7, iImm, iReady,
        input  oReady, oValid, oInst, oIllegal, oAccCnt, oIllCnt
    );

    modport slave (
        input  iValid, iOpcode, iRdAddr, iRs1Addr, iRs2Addr, iFunct3, iFunct7, iImm, iReady,
        output oReady, oValid, oInst, oIllegal, oAccCnt, oIllCnt
    );
endinterface

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: rebuilds a 32-bit instruction word from decoded fields,
// range-checks the immediate and substitutes a NOP for illegal requests.
module inst_encoder #(
    parameter int cycleNum = 2,
    parameter int cCntW    = 16
) (
    input  logic          iClk,
    input  logic          iRst,
    inst_encoder_if.slave bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic is_illegal(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] imm);
        logic sext12;
        logic illegal;
        sext12  = (&imm[31:11]) | ~(|imm[31:11]);
        illegal = 1'b1;
        case (op)
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5)
                    illegal = (|imm[31:5]) || !(f7 == 7'h00 || f7 == 7'h20);
                else
                    illegal = !sext12;
            end
            7'h03, 7'h67, 7'h0F, 7'h73, 7'h23: illegal = !sext12;
            7'h33:        illegal = 1'b0;
            7'h37, 7'h17: illegal = |imm[11:0];
            7'h63: illegal = !((&imm[31:12]) | ~(|imm[31:12])) || imm[0];
            7'h6F: illegal = !((&imm[31:20]) | ~(|imm[31:20])) || imm[0];
            default:      illegal = 1'b1;
        endcase
        return illegal;
    endfunction

    function automatic logic [31:0] encode(input logic [6:0] op, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [2:0] f3, input logic [6:0] f7,
                                           input logic [31:0] imm);
        logic [31:0] w;
        w = NOP;
        case (op)
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5)
                    w = {f7, imm[4:0], rs1, f3, rd, op};
                else
                    w = {imm[11:0], rs1, f3, rd, op};
            end
            7'h03, 7'h67, 7'h0F, 7'h73: w = {imm[11:0], rs1, f3, rd, op};
            7'h23:        w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            7'h33:        w = {f7, rs2, rs1, f3, rd, op};
            7'h37, 7'h17: w = {imm[31:12], rd, op};
            7'h63:        w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            7'h6F:        w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default:      w = NOP;
        endcase
        return w;
    endfunction

    logic             rdy;
    logic             accept;
    logic             reqIll;
    logic [cCntW-1:0] accCnt_q, accCnt_d, illCnt_q, illCnt_d;

    assign reqIll     = is_illegal(bus.iOpcode, bus.iFunct3, bus.iFunct7, bus.iImm);
    assign accept     = bus.iValid && rdy;
    assign bus.oReady = rdy;

    generate
        if (cycleNum == 1) begin : g_one
            logic        oValid_q;
            logic [31:0] oInst_q;
            logic        oIll_q;

            assign rdy = !oValid_q || bus.iReady;

            always_ff @(posedge iClk or negedge iRst) begin
                if (!iRst) begin
                    oValid_q <= 1'b0;
                    oInst_q  <= '0;
                    oIll_q   <= 1'b0;
                end else if (rdy) begin
                    oValid_q <= bus.iValid;
                    if (bus.iValid) begin
                        oInst_q <= reqIll ? NOP : encode(bus.iOpcode, bus.iRdAddr, bus.iRs1Addr,
                                                         bus.iRs2Addr, bus.iFunct3, bus.iFunct7,
                                                         bus.iImm);
                        oIll_q  <= reqIll;
                    end
                end
            end

            assign bus.oValid   = oValid_q;
            assign bus.oInst    = oInst_q;
            assign bus.oIllegal = oIll_q;
        end else begin : g_two
            logic        s1Valid_q, s2Valid_q, adv1, adv2;
            logic [6:0]  s1Op_q, s1F7_q;
            logic [4:0]  s1Rd_q, s1Rs1_q, s1Rs2_q;
            logic [2:0]  s1F3_q;
            logic [31:0] s1Imm_q;
            logic        s1Ill_q;
            logic [31:0] s2Inst_q;
            logic        s2Ill_q;

            assign adv2 = !s2Valid_q || bus.iReady;
            assign adv1 = !s1Valid_q || adv2;
            assign rdy  = adv1;

            // Stage 1: capture request fields and the range-check verdict
            always_ff @(posedge iClk) begin
                if (accept) begin
                    s1Op_q  <= bus.iOpcode;
                    s1Rd_q  <= bus.iRdAddr;
                    s1Rs1_q <= bus.iRs1Addr;
                    s1Rs2_q <= bus.iRs2Addr;
                    s1F3_q  <= bus.iFunct3;
                    s1F7_q  <= bus.iFunct7;
                    s1Imm_q <= bus.iImm;
                    s1Ill_q <= reqIll;
                end
            end

            // Stage 2: assemble the word; output registers are visible so they reset
            always_ff @(posedge iClk or negedge iRst) begin
                if (!iRst) begin
                    s1Valid_q <= 1'b0;
                    s2Valid_q <= 1'b0;
                    s2Inst_q  <= '0;
                    s2Ill_q   <= 1'b0;
                end else begin
                    if (adv1)
                        s1Valid_q <= bus.iValid;
                    if (adv2) begin
                        s2Valid_q <= s1Valid_q;
                        if (s1Valid_q) begin
                            s2Inst_q <= s1Ill_q ? NOP : encode(s1Op_q, s1Rd_q, s1Rs1_q, s1Rs2_q,
                                                               s1F3_q, s1F7_q, s1Imm_q);
                            s2Ill_q  <= s1Ill_q;
                        end
                    end
                end
            end

            assign bus.oValid   = s2Valid_q;
            assign bus.oInst    = s2Inst_q;
            assign bus.oIllegal = s2Ill_q;
        end
    endgenerate

    always_comb begin
        accCnt_d = accCnt_q;
        illCnt_d = illCnt_q;
        if (accept) begin
            accCnt_d = accCnt_q + {{(cCntW-1){1'b0}}, 1'b1};
            if (reqIll)
                illCnt_d = illCnt_q + {{(cCntW-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            accCnt_q <= '0;
            illCnt_q <= '0;
        end else begin
            accCnt_q <= accCnt_d;
            illCnt_q <= illCnt_d;
        end
    end

    assign bus.oAccCnt = accCnt_q;
    assign bus.oIllCnt = illCnt_q;
endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: two-stage and one-stage builds side by side.
module tb_inst_encoder;
    logic iClk = 1'b0;
    logic iRst;
    always #5 iClk = ~iClk;

    inst_encoder_if #(.cCntW(16)) b2 ();
    inst_encoder_if #(.cCntW(16)) b1 ();

    inst_encoder #(.cycleNum(2), .cCntW(16)) dut2 (.iClk(iClk), .iRst(iRst), .bus(b2.slave));
    inst_encoder #(.cycleNum(1), .cCntW(16)) dut1 (.iClk(iClk), .iRst(iRst), .bus(b1.slave));

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] inst;
        logic        ill;
    } vec_t;

    int vectors = 0;
    int errors  = 0;

    function automatic vec_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] imm, input logic [31:0] inst, input logic ill);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
        v.imm = imm; v.inst = inst; v.ill = ill;
        return v;
    endfunction

    task automatic drive2(input vec_t v);
        b2.iOpcode = v.op; b2.iRdAddr = v.rd; b2.iRs1Addr = v.rs1; b2.iRs2Addr = v.rs2;
        b2.iFunct3 = v.f3; b2.iFunct7 = v.f7; b2.iImm = v.imm; b2.iValid = 1'b1;
    endtask

    task automatic drive1(input vec_t v);
        b1.iOpcode = v.op; b1.iRdAddr = v.rd; b1.iRs1Addr = v.rs1; b1.iRs2Addr = v.rs2;
        b1.iFunct3 = v.f3; b1.iFunct7 = v.f7; b1.iImm = v.imm; b1.iValid = 1'b1;
    endtask

    task automatic apply_reset();
        b2.iValid = 1'b0;
        b1.iValid = 1'b0;
        iRst = 1'b0;
        @(posedge iClk); #1;
        iRst = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if (b2.oValid !== 1'b0 || b2.oInst !== 32'h0 || b2.oIllegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_out2: valid=%b inst=%h ill=%b, want 0/00000000/0", b2.oValid, b2.oInst, b2.oIllegal);
        end
        vectors++;
        if (b2.oAccCnt !== 16'd0 || b2.oIllCnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt2: acc=%0d ill=%0d, want 0/0", b2.oAccCnt, b2.oIllCnt);
        end
        vectors++;
        if (b1.oValid !== 1'b0 || b1.oInst !== 32'h0 || b1.oIllegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_out1: valid=%b inst=%h ill=%b, want 0/00000000/0", b1.oValid, b1.oInst, b1.oIllegal);
        end
    endtask

    task automatic test_addi();
        apply_reset();
        b2.iReady = 1'b1;
        drive2(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5, 32'h00500093, 1'b0));
        #1;
        vectors++;
        if (b2.oReady !== 1'b1) begin
            errors++;
            $display("FAIL addi_ready: got %b want 1", b2.oReady);
        end
        @(posedge iClk); #1;
        b2.iValid = 1'b0;
        vectors++;
        if (b2.oValid !== 1'b0) begin
            errors++;
            $display("FAIL addi_lat1: oValid=%b one cycle after accept, want 0", b2.oValid);
        end
        @(posedge iClk); #1;
        vectors++;
        if (b2.oValid !== 1'b1 || b2.oInst !== 32'h00500093 || b2.oIllegal !== 1'b0) begin
            errors++;
            $display("FAIL addi_out: valid=%b inst=%h ill=%b, want 1/00500093/0", b2.oValid, b2.oInst, b2.oIllegal);
        end
        vectors++;
        if (b2.oAccCnt !== 16'd1) begin
            errors++;
            $display("FAIL addi_acc: got %0d want 1", b2.oAccCnt);
        end
        @(posedge iClk); #1;
        vectors++;
        if (b2.oValid !== 1'b0) begin
            errors++;
            $display("FAIL addi_drain: oValid=%b want 0", b2.oValid);
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[4];
        int got;
        v[0] = mk(7'h23, 5'd31, 5'd1, 5'd2, 3'd2, 7'h7F, 32'd8,          32'h0020A423, 1'b0);
        v[1] = mk(7'h63, 5'd7,  5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFFC,   32'hFE208EE3, 1'b0);
        v[2] = mk(7'h6F, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,       32'h001000EF, 1'b0);
        v[3] = mk(7'h37, 5'd5,  5'd3, 5'd4, 3'd7, 7'h00, 32'h12345000,   32'h123452B7, 1'b0);
        apply_reset();
        b2.iReady = 1'b1;
        got = 0;
        for (int c = 0; c < 7; c++) begin
            if (c < 4) drive2(v[c]); else b2.iValid = 1'b0;
            @(posedge iClk); #1;
            vectors++;
            if (b2.oValid !== (c >= 1 && c <= 4)) begin
                errors++;
                $display("FAIL b2b_valid c=%0d: got %b want %b", c, b2.oValid, (c >= 1 && c <= 4));
            end
            if (b2.oValid === 1'b1 && got < 4) begin
                vectors++;
                if (b2.oInst !== v[got].inst || b2.oIllegal !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_inst%0d: inst=%h ill=%b, want %h/0", got, b2.oInst, b2.oIllegal, v[got].inst);
                end
                got++;
            end
        end
        vectors++;
        if (got !== 4 || b2.oAccCnt !== 16'd4) begin
            errors++;
            $display("FAIL b2b_count: outputs=%0d acc=%0d, want 4/4", got, b2.oAccCnt);
        end
    endtask

    task automatic test_illegal();
        vec_t v[8];
        int got;
        v[0] = mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,     32'h00000013, 1'b1);
        v[1] = mk(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd3,        32'h00000013, 1'b1);
        v[2] = mk(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'd0,        32'h00000013, 1'b1);
        v[3] = mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF800, 32'h80000093, 1'b0);
        v[4] = mk(7'h13, 5'd3, 5'd4, 5'd0, 3'd1, 7'h00, 32'd32,       32'h00000013, 1'b1);
        v[5] = mk(7'h13, 5'd3, 5'd4, 5'd0, 3'd5, 7'h20, 32'd7,        32'h40725193, 1'b0);
        v[6] = mk(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345001, 32'h00000013, 1'b1);
        v[7] = mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF00000, 32'h800000EF, 1'b0);
        apply_reset();
        b2.iReady = 1'b1;
        got = 0;
        for (int c = 0; c < 11; c++) begin
            if (c < 8) drive2(v[c]); else b2.iValid = 1'b0;
            @(posedge iClk); #1;
            if (b2.oValid === 1'b1 && got < 8) begin
                vectors++;
                if (b2.oInst !== v[got].inst || b2.oIllegal !== v[got].ill) begin
                    errors++;
                    $display("FAIL ill_vec%0d: inst=%h ill=%b, want %h/%b", got, b2.oInst, b2.oIllegal, v[got].inst, v[got].ill);
                end
                got++;
            end
        end
        vectors++;
        if (got !== 8 || b2.oAccCnt !== 16'd8 || b2.oIllCnt !== 16'd5) begin
            errors++;
            $display("FAIL ill_count: outputs=%0d acc=%0d ill=%0d, want 8/8/5", got, b2.oAccCnt, b2.oIllCnt);
        end
    endtask

    task automatic test_backpressure();
        int nxt, got;
        logic rdy, ov, ordy;
        logic [31:0] oi;
        apply_reset();
        b2.iReady = 1'b0;
        nxt = 0;
        got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            if (c == 5) b2.iReady = 1'b1;
            if (nxt < 5)
                drive2(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, nxt + 1, 32'h0, 1'b0));
            else
                b2.iValid = 1'b0;
            #1;
            rdy = b2.oReady; ov = b2.oValid; oi = b2.oInst; ordy = b2.iReady;
            if (c < 5) begin
                vectors++;
                if (rdy !== (c < 2)) begin
                    errors++;
                    $display("FAIL bp_ready c=%0d: got %b want %b", c, rdy, (c < 2));
                end
            end
            if (c >= 2 && c < 5) begin
                vectors++;
                if (ov !== 1'b1 || oi !== 32'h00100093) begin
                    errors++;
                    $display("FAIL bp_hold c=%0d: valid=%b inst=%h, want 1/00100093", c, ov, oi);
                end
            end
            @(posedge iClk);
            if (b2.iValid && rdy) nxt++;
            if (ov && ordy) begin
                vectors++;
                if (oi !== ((32'(got + 1) << 20) | 32'h93)) begin
                    errors++;
                    $display("FAIL bp_order%0d: got %h want %h", got, oi, (32'(got + 1) << 20) | 32'h93);
                end
                got++;
            end
            #1;
        end
        b2.iValid = 1'b0;
        @(posedge iClk); #1;
        vectors++;
        if (got !== 5 || b2.oValid !== 1'b0 || b2.oAccCnt !== 16'd5) begin
            errors++;
            $display("FAIL bp_count: outputs=%0d valid=%b acc=%0d, want 5/0/5", got, b2.oValid, b2.oAccCnt);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        b2.iReady = 1'b0;
        drive2(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1, 32'h0, 1'b0));
        @(posedge iClk); #1;
        drive2(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2, 32'h0, 1'b0));
        @(posedge iClk); #1;
        b2.iValid = 1'b0;
        vectors++;
        if (b2.oValid !== 1'b1 || b2.oAccCnt !== 16'd2) begin
            errors++;
            $display("FAIL rmid_pre: valid=%b acc=%0d, want 1/2", b2.oValid, b2.oAccCnt);
        end
        iRst = 1'b0;
        #1;
        vectors++;
        if (b2.oValid !== 1'b0 || b2.oAccCnt !== 16'd0 || b2.oIllCnt !== 16'd0 || b2.oInst !== 32'h0) begin
            errors++;
            $display("FAIL rmid_async: valid=%b acc=%0d ill=%0d inst=%h, want 0/0/0/0", b2.oValid, b2.oAccCnt, b2.oIllCnt, b2.oInst);
        end
        @(posedge iClk); #1;
        iRst = 1'b1;
        b2.iReady = 1'b1;
        @(posedge iClk); #1;
        vectors++;
        if (b2.oValid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_release: oValid=%b want 0", b2.oValid);
        end
        drive2(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5, 32'h0, 1'b0));
        @(posedge iClk); #1;
        b2.iValid = 1'b0;
        @(posedge iClk); #1;
        vectors++;
        if (b2.oValid !== 1'b1 || b2.oInst !== 32'h00500093 || b2.oAccCnt !== 16'd1) begin
            errors++;
            $display("FAIL rmid_after: valid=%b inst=%h acc=%0d, want 1/00500093/1", b2.oValid, b2.oInst, b2.oAccCnt);
        end
    endtask

    task automatic test_cycle1();
        vec_t v[3];
        v[0] = mk(7'h23, 5'd31, 5'd1, 5'd2, 3'd2, 7'h7F, 32'd8,        32'h0020A423, 1'b0);
        v[1] = mk(7'h63, 5'd7,  5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0);
        v[2] = mk(7'h7F, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'd0,        32'h00000013, 1'b1);
        apply_reset();
        b1.iReady = 1'b1;
        drive1(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5, 32'h0, 1'b0));
        @(posedge iClk); #1;
        b1.iValid = 1'b0;
        vectors++;
        if (b1.oValid !== 1'b1 || b1.oInst !== 32'h00500093 || b1.oIllegal !== 1'b0) begin
            errors++;
            $display("FAIL c1_addi: valid=%b inst=%h ill=%b, want 1/00500093/0", b1.oValid, b1.oInst, b1.oIllegal);
        end
        @(posedge iClk); #1;
        vectors++;
        if (b1.oValid !== 1'b0) begin
            errors++;
            $display("FAIL c1_drain: oValid=%b want 0", b1.oValid);
        end
        for (int c = 0; c < 3; c++) begin
            drive1(v[c]);
            @(posedge iClk); #1;
            vectors++;
            if (b1.oValid !== 1'b1 || b1.oInst !== v[c].inst || b1.oIllegal !== v[c].ill) begin
                errors++;
                $display("FAIL c1_stream%0d: valid=%b inst=%h ill=%b, want 1/%h/%b", c, b1.oValid, b1.oInst, b1.oIllegal, v[c].inst, v[c].ill);
            end
        end
        b1.iValid = 1'b0;
        vectors++;
        if (b1.oAccCnt !== 16'd4 || b1.oIllCnt !== 16'd1) begin
            errors++;
            $display("FAIL c1_count: acc=%0d ill=%0d, want 4/1", b1.oAccCnt, b1.oIllCnt);
        end
    endtask

    initial begin
        iRst = 1'b0;
        b2.iValid = 1'b0; b2.iReady = 1'b1;
        b1.iValid = 1'b0; b1.iReady = 1'b1;
        drive2(mk(7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0, 32'h0, 1'b0));
        drive1(mk(7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0, 32'h0, 1'b0));
        b2.iValid = 1'b0;
        b1.iValid = 1'b0;
        test_reset();
        test_addi();
        test_back_to_back();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        test_cycle1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
